// File: rtl/mar_mdr_pkg.sv
// Shared opcode and FSM encodings for the MAR/MDR memory model.
package mar_mdr_pkg;

    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_LD_ADDR = 3'd1,
        OP_LD_DATA = 3'd2,
        OP_RD_ADDR = 3'd3,
        OP_RD_DATA = 3'd4,
        OP_MEM_WR  = 3'd5,
        OP_MEM_RD  = 3'd6,
        OP_RSVD    = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic is_mem_op(op_e op);
        return (op == OP_MEM_WR) || (op == OP_MEM_RD);
    endfunction

endpackage

// File: rtl/mar_mdr_memory_sp_ram.sv
// Synchronous single-port word array; rdata is re-registered from addr every cycle.
module sp_ram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned AW     = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // addr (the MAR) is stable for at least one edge before any read commit,
    // so the registered rdata already holds mem[addr] at the commit edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mar_mdr_memory.sv
// Memory model fronted by MAR/MDR registers with valid/ready command and response channels.
module mar_mdr_memory
    import mar_mdr_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned ACC_LAT  = 2,
    parameter int unsigned AUTO_INC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy
);

    localparam int unsigned RAM_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  CNT_INIT = (ACC_LAT == 0) ? 4'd0 : 4'(ACC_LAT - 1);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    op_e               exec_op;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
    logic              accept, execute, in_range, ram_we;
    logic [DATA_W-1:0] ram_rdata;

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign accept    = cmd_valid && cmd_ready;
    assign in_range  = 32'(mar_q) < DEPTH;

    sp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (RAM_AW'(mar_q)),
        .wdata (mdr_q),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        mar_d      = mar_q;
        mdr_d      = mdr_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        ram_we     = 1'b0;
        execute    = 1'b0;
        exec_op    = (state_q == ST_WAIT) ? op_q : op_e'(cmd_op);

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_mem_op(op_e'(cmd_op)) && (ACC_LAT != 0)) begin
                        op_d    = op_e'(cmd_op);
                        cnt_d   = CNT_INIT;
                        state_d = ST_WAIT;
                    end else begin
                        execute = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    execute = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (execute) begin
            rsp_data_d = '0;
            rsp_err_d  = 1'b0;
            unique case (exec_op)
                OP_LD_ADDR: mar_d = ADDR_W'(cmd_wdata);
                OP_LD_DATA: mdr_d = cmd_wdata;
                OP_RD_ADDR: rsp_data_d = DATA_W'(mar_q);
                OP_RD_DATA: rsp_data_d = mdr_q;
                OP_MEM_WR, OP_MEM_RD: begin
                    if (in_range) begin
                        if (exec_op == OP_MEM_WR) begin
                            ram_we = 1'b1;
                        end else begin
                            mdr_d      = ram_rdata;
                            rsp_data_d = ram_rdata;
                        end
                        // Wrap at DEPTH, not at the MAR's natural width.
                        if (AUTO_INC != 0) begin
                            mar_d = (32'(mar_q) == DEPTH - 1) ? '0 : mar_q + ADDR_W'(1);
                        end
                    end else begin
                        rsp_err_d = 1'b1;
                    end
                end
                OP_RSVD: rsp_err_d = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_NOP;
            cnt_q      <= 4'd0;
            mar_q      <= '0;
            mdr_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            mar_q      <= mar_d;
            mdr_q      <= mdr_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_mar_mdr_memory.sv
// Bench driving a DEPTH=256 and a DEPTH=16 instance in lockstep against a behavioural model.
module tb_mar_mdr_memory;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_op = 3'd0;
    logic [7:0] cmd_wdata = 8'd0;
    logic       rsp_ready = 1'b0;
    logic [1:0] cmd_ready, rsp_valid, rsp_err, busy;
    logic [7:0] rsp_data [2];

    int tests = 0;
    int fails = 0;
    int m_mar [2];
    int m_mdr [2];
    int m_mem [2][256];
    bit last_err [2];

    always #5 clk = ~clk;

    mar_mdr_memory u_dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready[0]),
        .cmd_op    (cmd_op),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid[0]),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data[0]),
        .rsp_err   (rsp_err[0]),
        .busy      (busy[0])
    );

    mar_mdr_memory #(.DEPTH(16)) u_dut16 (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready[1]),
        .cmd_op    (cmd_op),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid[1]),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data[1]),
        .rsp_err   (rsp_err[1]),
        .busy      (busy[1])
    );

    // Architectural model: registers and memory as plain integers.
    function automatic void model_exec(input int d, input int op, input int wdata,
                                       output int ed, output bit ee);
        int depth = (d == 0) ? 256 : 16;
        ed = 0;
        ee = 1'b0;
        case (op)
            1: m_mar[d] = wdata % 256;
            2: m_mdr[d] = wdata % 256;
            3: ed = m_mar[d];
            4: ed = m_mdr[d];
            5, 6: begin
                if (m_mar[d] < depth) begin
                    if (op == 5) begin
                        m_mem[d][m_mar[d]] = m_mdr[d];
                    end else begin
                        m_mdr[d] = m_mem[d][m_mar[d]];
                        ed = m_mdr[d];
                    end
                    m_mar[d] = (m_mar[d] + 1) % depth;
                end else begin
                    ee = 1'b1;
                end
            end
            7: ee = 1'b1;
            default: ;
        endcase
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_mar[d] = 0;
            m_mdr[d] = 0;
        end
    endtask

    // One full transaction, entered and left at a negedge.
    task automatic do_cmd(input int op, input int wdata, input int hold,
                          output int got0, output int got1);
        int ed [2];
        bit ee [2];
        int lat;
        int exp_lat;
        model_exec(0, op, wdata, ed[0], ee[0]);
        model_exec(1, op, wdata, ed[1], ee[1]);
        exp_lat = (op == 5 || op == 6) ? 3 : 1;
        lat = 0;
        while (cmd_ready !== 2'b11 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        tests++;
        if (cmd_ready !== 2'b11) begin
            fails++;
            $display("FAIL cmd_ready_timeout: got %b want 11", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_op    = 3'(op);
        cmd_wdata = 8'(wdata);
        rsp_ready = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == 1) begin
                cmd_valid = 1'b0;
                cmd_op    = 3'($urandom);
                cmd_wdata = 8'($urandom);
            end
            tests++;
            if (busy !== 2'b11) begin
                fails++;
                $display("FAIL busy_in_flight op%0d: got %b want 11", op, busy);
            end
        end while (rsp_valid[0] !== 1'b1 && lat < 40);
        tests++;
        if (lat !== exp_lat) begin
            fails++;
            $display("FAIL latency op%0d: got %0d want %0d", op, lat, exp_lat);
        end
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (rsp_valid[d] !== 1'b1 || rsp_data[d] !== 8'(ed[d]) || rsp_err[d] !== ee[d]) begin
                fails++;
                $display("FAIL rsp op%0d dut%0d: got v=%b d=%h e=%b want v=1 d=%h e=%b",
                         op, d, rsp_valid[d], rsp_data[d], rsp_err[d], 8'(ed[d]), ee[d]);
            end
        end
        got0 = rsp_data[0];
        got1 = rsp_data[1];
        last_err[0] = rsp_err[0];
        last_err[1] = rsp_err[1];
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                tests++;
                if (rsp_valid[d] !== 1'b1 || rsp_data[d] !== 8'(ed[d]) ||
                    rsp_err[d] !== ee[d] || cmd_ready[d] !== 1'b0) begin
                    fails++;
                    $display("FAIL hold op%0d dut%0d: got v=%b d=%h e=%b rdy=%b want v=1 d=%h e=%b rdy=0",
                             op, d, rsp_valid[d], rsp_data[d], rsp_err[d], cmd_ready[d],
                             8'(ed[d]), ee[d]);
                end
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        tests++;
        if (rsp_valid !== 2'b00 || cmd_ready !== 2'b11 || busy !== 2'b00) begin
            fails++;
            $display("FAIL release op%0d: got v=%b rdy=%b busy=%b want v=00 rdy=11 busy=00",
                     op, rsp_valid, cmd_ready, busy);
        end
    endtask

    task automatic test_reset();
        int g0, g1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (rsp_valid[d] !== 1'b0 || rsp_data[d] !== 8'h00 || rsp_err[d] !== 1'b0 ||
                busy[d] !== 1'b0 || cmd_ready[d] !== 1'b1) begin
                fails++;
                $display("FAIL reset_outputs dut%0d: got v=%b d=%h e=%b busy=%b rdy=%b want 0 00 0 0 1",
                         d, rsp_valid[d], rsp_data[d], rsp_err[d], busy[d], cmd_ready[d]);
            end
        end
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        do_cmd(3, 0, 0, g0, g1);
        tests++;
        if (g0 !== 0) begin
            fails++;
            $display("FAIL reset_mar: got %h want 00", g0);
        end
        do_cmd(4, 0, 0, g0, g1);
        tests++;
        if (g0 !== 0) begin
            fails++;
            $display("FAIL reset_mdr: got %h want 00", g0);
        end
    endtask

    task automatic test_fill();
        int g0, g1;
        do_cmd(1, 0, 0, g0, g1);
        for (int i = 0; i < 256; i++) begin
            do_cmd(2, $urandom_range(0, 255), 0, g0, g1);
            do_cmd(5, 0, 0, g0, g1);
        end
    endtask

    task automatic test_autoinc();
        int g0, g1;
        do_cmd(1, 'h10, 0, g0, g1);
        do_cmd(2, 'hA5, 0, g0, g1);
        do_cmd(5, 0, 0, g0, g1);
        do_cmd(3, 0, 0, g0, g1);
        tests++;
        if (g0 !== 'h11) begin
            fails++;
            $display("FAIL autoinc_mar: got %h want 11", g0);
        end
        do_cmd(1, 'h10, 0, g0, g1);
        do_cmd(6, 0, 0, g0, g1);
        tests++;
        if (g0 !== 'hA5) begin
            fails++;
            $display("FAIL mem_rd_a5: got %h want a5", g0);
        end
    endtask

    task automatic test_wrap();
        int g0, g1;
        do_cmd(1, 'h0F, 0, g0, g1);
        do_cmd(2, 'h3C, 0, g0, g1);
        do_cmd(5, 0, 0, g0, g1);
        do_cmd(3, 0, 0, g0, g1);
        tests++;
        if (g1 !== 0 || g0 !== 'h10) begin
            fails++;
            $display("FAIL wrap_mar: got d16=%h d256=%h want 00 10", g1, g0);
        end
        do_cmd(1, 'h20, 0, g0, g1);
        do_cmd(6, 0, 0, g0, g1);
        tests++;
        if (last_err[1] !== 1'b1 || g1 !== 0) begin
            fails++;
            $display("FAIL oor_err: got e=%b d=%h want e=1 d=00", last_err[1], g1);
        end
        do_cmd(4, 0, 0, g0, g1);
        tests++;
        if (g1 !== 'h3C) begin
            fails++;
            $display("FAIL oor_mdr_kept: got %h want 3c", g1);
        end
    endtask

    task automatic test_rsvd();
        int g0, g1;
        do_cmd(7, 'hFF, 5, g0, g1);
        tests++;
        if (last_err[0] !== 1'b1 || g0 !== 0) begin
            fails++;
            $display("FAIL rsvd: got e=%b d=%h want e=1 d=00", last_err[0], g0);
        end
    endtask

    task automatic test_reset_abort();
        int g0, g1;
        do_cmd(1, 'h05, 0, g0, g1);
        do_cmd(2, 'h77, 0, g0, g1);
        do_cmd(5, 0, 0, g0, g1);
        do_cmd(1, 'h05, 0, g0, g1);
        do_cmd(2, 'h99, 0, g0, g1);
        cmd_valid = 1'b1;
        cmd_op    = 3'd5;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        tests++;
        if (busy !== 2'b11 || rsp_valid !== 2'b00) begin
            fails++;
            $display("FAIL abort_wait: got busy=%b v=%b want 11 00", busy, rsp_valid);
        end
        rst = 1'b1;
        #1;
        tests++;
        if (busy !== 2'b00 || cmd_ready !== 2'b11 || rsp_valid !== 2'b00) begin
            fails++;
            $display("FAIL async_reset: got busy=%b rdy=%b v=%b want 00 11 00",
                     busy, cmd_ready, rsp_valid);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests++;
            if (rsp_valid !== 2'b00) begin
                fails++;
                $display("FAIL abort_no_rsp: got %b want 00", rsp_valid);
            end
        end
        do_cmd(3, 0, 0, g0, g1);
        tests++;
        if (g0 !== 0) begin
            fails++;
            $display("FAIL abort_mar: got %h want 00", g0);
        end
        do_cmd(1, 'h05, 0, g0, g1);
        do_cmd(6, 0, 0, g0, g1);
        tests++;
        if (g0 !== 'h77 || g1 !== 'h77) begin
            fails++;
            $display("FAIL abort_no_write: got %h/%h want 77", g0, g1);
        end
    endtask

    task automatic test_random();
        int g0, g1, op, wd;
        for (int i = 0; i < 300; i++) begin
            op = $urandom_range(0, 7);
            wd = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 15);
            do_cmd(op, wd, $urandom_range(0, 3), g0, g1);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_autoinc();
        test_wrap();
        test_rsvd();
        test_reset_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", fails);
        $fatal(1, "watchdog expired");
    end

endmodule
